// File: rtl/timer_unit.sv
// Memory-mapped cycle timer for the data bus.
// Drives the sticky TimerInterrupt level into cp0.
module timer_unit #(
    parameter logic [31:0] CYCLE_ADDR   = 32'hffff001c,
    parameter logic [31:0] ACK_ADDR     = 32'hffff006c,
    parameter logic [31:0] INIT_COMPARE = 32'hffffffff
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] cycle,
    output logic        TimerAddress,
    output logic        TimerInterrupt
);

    logic [31:0] cycle_count;
    logic [31:0] interrupt_cycle;
    logic        int_flag;
    logic        hit_cycle;
    logic        hit_ack;
    logic        match;

    // Address decode and combinational read path
    always_comb begin
        hit_cycle    = (address == CYCLE_ADDR);
        hit_ack      = (address == ACK_ADDR);
        TimerAddress = hit_cycle | hit_ack;
        match        = (cycle_count == interrupt_cycle);
        cycle        = (MemRead && hit_cycle) ? cycle_count : 32'b0;
    end

    // Free-running counter; wraps silently
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Compare register loaded by software writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            interrupt_cycle <= INIT_COMPARE;
        end else if (MemWrite && hit_cycle) begin
            interrupt_cycle <= data;
        end
    end

    // Sticky interrupt; an acknowledge beats a coincident match
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            int_flag <= 1'b0;
        end else if (MemWrite && hit_ack) begin
            int_flag <= 1'b0;
        end else if (match) begin
            int_flag <= 1'b1;
        end
    end

    assign TimerInterrupt = int_flag;

endmodule

// File: tb/tb_timer_unit.sv
// Directed self-checking bench for timer_unit.
// Expected values are tracked by a local cycle model.
module tb_timer_unit;

    localparam logic [31:0] CA = 32'hffff001c;
    localparam logic [31:0] AA = 32'hffff006c;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] cycle;
    logic        TimerAddress;
    logic        TimerInterrupt;

    int          n_cmp;
    int          n_bad;
    logic [31:0] cnt;

    timer_unit dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .data          (data),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .cycle         (cycle),
        .TimerAddress  (TimerAddress),
        .TimerInterrupt(TimerInterrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n clocks; sample point is the falling edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            cnt = cnt + 32'd1;
        end
    endtask

    // Short reset pulse while the clock is low
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        cnt   = 32'd0;
    endtask

    task automatic idle_bus();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        address  = 32'h0;
        data     = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_bus();
        #2;
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq got=%b exp=0", TimerInterrupt);
        end
        n_cmp++;
        if (cycle !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cycle got=%h exp=0", cycle);
        end
        @(negedge clock);
        reset = 1'b1;
        cnt   = 32'd0;
        cyc(10);
        MemRead = 1'b1;
        address = CA;
        #1;
        n_cmp++;
        if (cycle !== 32'd10) begin
            n_bad++;
            $display("FAIL count10 got=%0d exp=10", cycle);
        end
        n_cmp++;
        if (TimerAddress !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_hit got=%b exp=1", TimerAddress);
        end
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL count10_irq got=%b exp=0", TimerInterrupt);
        end
        idle_bus();
    endtask

    task automatic test_fire();
        pulse_reset();
        cyc(5);
        MemWrite = 1'b1;
        address  = CA;
        data     = 32'd20;
        cyc(1);
        idle_bus();
        while (cnt <= 32'd20) begin
            n_cmp++;
            if (TimerInterrupt !== 1'b0) begin
                n_bad++;
                $display("FAIL early_irq cnt=%0d got=%b exp=0",
                         cnt, TimerInterrupt);
            end
            cyc(1);
        end
        MemRead = 1'b1;
        address = CA;
        #1;
        n_cmp++;
        if (cycle !== 32'd21) begin
            n_bad++;
            $display("FAIL read21 got=%0d exp=21", cycle);
        end
        n_cmp++;
        if (TimerInterrupt !== 1'b1) begin
            n_bad++;
            $display("FAIL fire got=%b exp=1", TimerInterrupt);
        end
        idle_bus();
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            n_cmp++;
            if (TimerInterrupt !== 1'b1) begin
                n_bad++;
                $display("FAIL sticky i=%0d got=%b exp=1",
                         i, TimerInterrupt);
            end
        end
    endtask

    task automatic test_ack();
        MemWrite = 1'b1;
        address  = AA;
        data     = 32'hdeadbeef;
        #1;
        n_cmp++;
        if (TimerAddress !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_hit got=%b exp=1", TimerAddress);
        end
        cyc(1);
        idle_bus();
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_clear got=%b exp=0", TimerInterrupt);
        end
        cyc(3);
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_hold got=%b exp=0", TimerInterrupt);
        end
        pulse_reset();
        MemWrite = 1'b1;
        address  = CA;
        data     = 32'd40;
        cyc(1);
        idle_bus();
        cyc(39);
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL at40 cnt=%0d got=%b exp=0",
                     cnt, TimerInterrupt);
        end
        cyc(1);
        n_cmp++;
        if (TimerInterrupt !== 1'b1) begin
            n_bad++;
            $display("FAIL refire cnt=%0d got=%b exp=1",
                     cnt, TimerInterrupt);
        end
    endtask

    task automatic test_collision();
        MemWrite = 1'b1;
        address  = AA;
        cyc(1);
        address  = CA;
        data     = 32'd50;
        cyc(1);
        idle_bus();
        while (cnt < 32'd50) cyc(1);
        MemWrite = 1'b1;
        address  = AA;
        data     = 32'h1;
        cyc(1);
        idle_bus();
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL collide got=%b exp=0", TimerInterrupt);
        end
        cyc(3);
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_hold got=%b exp=0", TimerInterrupt);
        end
    endtask

    task automatic test_decode();
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        address  = 32'h10010000;
        data     = cnt + 32'd3;
        #1;
        n_cmp++;
        if (cycle !== 32'h0) begin
            n_bad++;
            $display("FAIL other_cycle got=%h exp=0", cycle);
        end
        n_cmp++;
        if (TimerAddress !== 1'b0) begin
            n_bad++;
            $display("FAIL other_hit got=%b exp=0", TimerAddress);
        end
        cyc(1);
        idle_bus();
        cyc(5);
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL other_write got=%b exp=0", TimerInterrupt);
        end
        MemRead = 1'b1;
        address = AA;
        #1;
        n_cmp++;
        if (cycle !== 32'h0) begin
            n_bad++;
            $display("FAIL ack_read got=%h exp=0", cycle);
        end
        n_cmp++;
        if (TimerAddress !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_read_hit got=%b exp=1", TimerAddress);
        end
        address  = CA;
        MemWrite = 1'b1;
        data     = cnt + 32'd2;
        #1;
        n_cmp++;
        if (cycle !== cnt) begin
            n_bad++;
            $display("FAIL rw_read got=%0d exp=%0d", cycle, cnt);
        end
        cyc(1);
        idle_bus();
        cyc(1);
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_early got=%b exp=0", TimerInterrupt);
        end
        cyc(1);
        n_cmp++;
        if (TimerInterrupt !== 1'b1) begin
            n_bad++;
            $display("FAIL rw_fire got=%b exp=1", TimerInterrupt);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        dut.cycle_count = 32'hfffffffd;
        cnt = 32'hfffffffd;
        MemRead = 1'b1;
        address = CA;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (cycle !== cnt) begin
                n_bad++;
                $display("FAIL top_read got=%h exp=%h", cycle, cnt);
            end
            n_cmp++;
            if (TimerInterrupt !== 1'b0) begin
                n_bad++;
                $display("FAIL top_irq cnt=%h got=%b exp=0",
                         cnt, TimerInterrupt);
            end
            cyc(1);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (cycle !== 32'(i)) begin
                n_bad++;
                $display("FAIL wrap_read got=%h exp=%0d", cycle, i);
            end
            n_cmp++;
            if (TimerInterrupt !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap_irq got=%b exp=1", TimerInterrupt);
            end
            cyc(1);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (TimerInterrupt !== 1'b0) begin
            n_bad++;
            $display("FAIL async_irq got=%b exp=0", TimerInterrupt);
        end
        n_cmp++;
        if (cycle !== 32'h0) begin
            n_bad++;
            $display("FAIL async_cycle got=%h exp=0", cycle);
        end
        reset = 1'b1;
        cnt   = 32'd0;
        cyc(1);
        #1;
        n_cmp++;
        if (cycle !== 32'd1) begin
            n_bad++;
            $display("FAIL restart got=%0d exp=1", cycle);
        end
        idle_bus();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cnt   = 32'd0;
        test_reset();
        test_fire();
        test_ack();
        test_collision();
        test_decode();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
